// File: rtl/id_ex_stage_skid.sv
// ID->EX stage register with a 2-entry skid buffer and flush.
// in_ready is registered from next state, so there is no comb path from out_ready.
module id_ex_stage_skid #(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int ALUOP_W    = 4,
  localparam int CTRL_W     = ALUOP_W + 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic [DATA_W-1:0]       pc_plus4_in,
  input  logic [DATA_W-1:0]       rs_data_in,
  input  logic [DATA_W-1:0]       rt_data_in,
  input  logic [DATA_W-1:0]       imm_in,
  input  logic [3*REG_ADDR_W-1:0] reg_addr_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic [DATA_W-1:0]       pc_plus4_out,
  output logic [DATA_W-1:0]       rs_data_out,
  output logic [DATA_W-1:0]       rt_data_out,
  output logic [DATA_W-1:0]       imm_out,
  output logic [REG_ADDR_W-1:0]   rs_out,
  output logic [REG_ADDR_W-1:0]   rt_out,
  output logic [REG_ADDR_W-1:0]   rd_out
);

  localparam int R      = REG_ADDR_W;
  localparam int IMM_LO = 3 * R;
  localparam int RT_LO  = IMM_LO + DATA_W;
  localparam int RS_LO  = RT_LO + DATA_W;
  localparam int PC_LO  = RS_LO + DATA_W;
  localparam int CT_LO  = PC_LO + DATA_W;
  localparam int SLOT_W = CT_LO + CTRL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] main_q, main_d;
  logic [SLOT_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [SLOT_W-1:0] in_slot;
  logic              accept, drain;

  assign in_slot = {ctrl_in, pc_plus4_in, rs_data_in,
                    rt_data_in, imm_in, reg_addr_in};
  assign accept  = in_valid & in_ready_q;
  assign drain   = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d[CT_LO +: CTRL_W] = '0;
      skid_d[CT_LO +: CTRL_W] = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_slot;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_slot;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_slot;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  // Bubbles must never carry side-effect controls into execute.
  assign ctrl_out     = out_valid_q ? main_q[CT_LO +: CTRL_W] : '0;
  assign pc_plus4_out = main_q[PC_LO +: DATA_W];
  assign rs_data_out  = main_q[RS_LO +: DATA_W];
  assign rt_data_out  = main_q[RT_LO +: DATA_W];
  assign imm_out      = main_q[IMM_LO +: DATA_W];
  assign rs_out       = main_q[2*R +: R];
  assign rt_out       = main_q[R +: R];
  assign rd_out       = main_q[0 +: R];

endmodule
